// File: rtl/uart_pkg.sv
// Shared types and elaboration helpers for the parametrised UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  // Clocks per line bit, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

  function automatic int unsigned frame_bits(input int unsigned data_bits,
                                             input int unsigned parity_mode,
                                             input int unsigned stop_bits);
    return 1 + data_bits + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered level and full flag; head is read combinationally.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full_q;
  logic             do_push, do_pop;

  // The registered full flag alone decides; a same-cycle pop does not admit a write.
  assign do_push = push & ~full_q;
  assign do_pop  = pop & (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == (AW + 1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  assign rdata = mem_q[rptr_q];
  assign full  = full_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter with a small TX FIFO; frames are sent back to back.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter int unsigned BAUD        = 19_200,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 1,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 TxD_start,
  input  logic [DATA_BITS-1:0] TxD_data,
  output logic                 TxD,
  output logic                 TxD_busy,
  output logic                 TxD_full,
  output logic                 TxD_overflow
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : gen_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be within 5..9");
  end
  if (PARITY_MODE > PARITY_EVEN) begin : gen_bad_parity
    $error("uart_tx_fifo: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : gen_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gen_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2 and at least 2");
  end

  localparam int unsigned Div     = calc_div(CLK_FREQ, BAUD);
  localparam int unsigned StopLen = STOP_BITS * Div;
  localparam int unsigned CntW    = $clog2(StopLen + 1);
  localparam int unsigned IdxW    = $clog2(DATA_BITS);

  uart_state_e          state_q;
  logic [CntW-1:0]      cnt_q;
  logic [IdxW-1:0]      idx_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 txd_q;
  logic                 ovf_q;

  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full, fifo_empty;
  logic                 pop;
  logic                 bit_done, stop_done, par_bit;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (TxD_start),
    .wdata (TxD_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bit_done  = (cnt_q == CntW'(Div - 1));
  assign stop_done = (cnt_q == CntW'(StopLen - 1));
  assign par_bit   = (PARITY_MODE == PARITY_ODD) ? ~^data_q : ^data_q;

  // One pop per frame: from idle, or chained straight out of the last stop clock.
  assign pop = ~fifo_empty & ((state_q == StIdle) | ((state_q == StStop) & stop_done));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q <= TxD_start & fifo_full;
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            data_q  <= fifo_rdata;
            cnt_q   <= '0;
            txd_q   <= 1'b0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (bit_done) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            txd_q   <= data_q[0];
            state_q <= StData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (bit_done) begin
            cnt_q <= '0;
            if (idx_q == IdxW'(DATA_BITS - 1)) begin
              if (PARITY_MODE != PARITY_NONE) begin
                txd_q   <= par_bit;
                state_q <= StParity;
              end else begin
                txd_q   <= 1'b1;
                state_q <= StStop;
              end
            end else begin
              idx_q <= idx_q + 1'b1;
              txd_q <= data_q[idx_q + 1'b1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StParity: begin
          if (bit_done) begin
            cnt_q   <= '0;
            txd_q   <= 1'b1;
            state_q <= StStop;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (stop_done) begin
            cnt_q <= '0;
            if (pop) begin
              data_q  <= fifo_rdata;
              txd_q   <= 1'b0;
              state_q <= StStart;
            end else begin
              txd_q   <= 1'b1;
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          txd_q   <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign TxD          = txd_q;
  assign TxD_busy     = (state_q != StIdle) | ~fifo_empty;
  assign TxD_full     = fifo_full;
  assign TxD_overflow = ovf_q;

endmodule
